// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rsn_sequencer.sv
// ============================================================================
// Module  : gf180mcu_fd_sc_mcu7t5v0__rsn_sequencer
// Brief   : Generates active-low RN/SETN controls for a set/reset flop bank.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gf180mcu_fd_sc_mcu7t5v0__rsn_sequencer #(
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_CYCLES  = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr_req,
    input  logic i_set_req,
    output logic o_rn,
    output logic o_setn,
    output logic o_busy,
    output logic o_ack
);

    localparam int c_MAX_A = (HOLD_CYCLES > PULSE_CYCLES) ? HOLD_CYCLES : PULSE_CYCLES;
    localparam int c_MAX   = (c_MAX_A > GAP_CYCLES) ? c_MAX_A : GAP_CYCLES;
    localparam int c_CNT_W = $clog2(c_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_HOLD = 3'd0,
        S_IDLE = 3'd1,
        S_CLR  = 3'd2,
        S_SET  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic                 r_pend_clr;
    logic                 r_pend_set;
    logic                 w_pend_clr_nxt;
    logic                 w_pend_set_nxt;
    logic                 w_pulse_end;
    logic                 w_released;
    logic                 w_want_clr;
    logic                 w_want_set;
    logic                 w_accept;
    logic                 r_rn;
    logic                 r_setn;
    logic                 r_ack;

    assign w_released = r_sync[SYNC_STAGES-1];
    assign w_want_clr = r_pend_clr | i_clr_req;
    assign w_want_set = r_pend_set | i_set_req;
    assign w_accept   = (r_state != S_HOLD);

    always_comb begin
        w_state_nxt = r_state;
        w_pulse_end = 1'b0;
        case (r_state)
            S_HOLD: begin
                if (w_released && (r_cnt == c_HOLD_LAST)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_want_clr) begin
                    w_state_nxt = S_CLR;
                end else if (w_want_set) begin
                    w_state_nxt = S_SET;
                end
            end
            S_CLR, S_SET: begin
                if (r_cnt == c_PULSE_LAST) begin
                    w_state_nxt = S_GAP;
                    w_pulse_end = 1'b1;
                end
            end
            S_GAP: begin
                // The last gap cycle dispatches directly so pulses can run back to back.
                if (r_cnt == c_GAP_LAST) begin
                    if (w_want_clr) begin
                        w_state_nxt = S_CLR;
                    end else if (w_want_set) begin
                        w_state_nxt = S_SET;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_HOLD;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_cnt + c_CNT_W'(1);
        if ((w_state_nxt != r_state) || (r_state == S_IDLE) ||
            ((r_state == S_HOLD) && !w_released)) begin
            w_cnt_nxt = '0;
        end
        w_pend_clr_nxt = (r_pend_clr | (i_clr_req & w_accept)) &
                         ~((w_state_nxt == S_CLR) && (r_state != S_CLR));
        w_pend_set_nxt = (r_pend_set | (i_set_req & w_accept)) &
                         ~((w_state_nxt == S_SET) && (r_state != S_SET));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_HOLD;
            r_sync     <= '0;
            r_cnt      <= '0;
            r_pend_clr <= 1'b0;
            r_pend_set <= 1'b0;
            r_rn       <= 1'b0;
            r_setn     <= 1'b1;
            r_ack      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync     <= {r_sync[SYNC_STAGES-2:0], 1'b1};
            r_cnt      <= w_cnt_nxt;
            r_pend_clr <= w_pend_clr_nxt;
            r_pend_set <= w_pend_set_nxt;
            // Outputs are decoded from the next state so they are clean flop outputs.
            r_rn       <= !((w_state_nxt == S_HOLD) || (w_state_nxt == S_CLR));
            r_setn     <= (w_state_nxt != S_SET);
            r_ack      <= w_pulse_end;
        end
    end

    assign o_rn   = r_rn;
    assign o_setn = r_setn;
    assign o_ack  = r_ack;
    assign o_busy = (r_state != S_IDLE) | r_pend_clr | r_pend_set;

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rsn_sequencer.sv
// ============================================================================
// Module  : tb_gf180mcu_fd_sc_mcu7t5v0__rsn_sequencer
// Brief   : Directed self-checking bench for the RN/SETN sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gf180mcu_fd_sc_mcu7t5v0__rsn_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clr, set, rn, setn, busy, ack;
    logic rst2, clr2, set2, rn2, setn2, busy2, ack2;
    int   total = 0;
    int   bad   = 0;

    gf180mcu_fd_sc_mcu7t5v0__rsn_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_clr_req(clr), .i_set_req(set),
        .o_rn(rn), .o_setn(setn), .o_busy(busy), .o_ack(ack)
    );

    gf180mcu_fd_sc_mcu7t5v0__rsn_sequencer #(
        .SYNC_STAGES(2), .HOLD_CYCLES(1), .PULSE_CYCLES(1), .GAP_CYCLES(1)
    ) dut_fast (
        .i_clk(clk), .i_rst(rst2), .i_clr_req(clr2), .i_set_req(set2),
        .o_rn(rn2), .o_setn(setn2), .o_busy(busy2), .o_ack(ack2)
    );

    // RN and SETN must never be low together on either instance.
    always @(negedge clk) begin
        total++;
        if ((rn === 1'b0) && (setn === 1'b0)) begin
            bad++;
            $display("FAIL invariant dut: rn=%b setn=%b required not both 0", rn, setn);
        end
        total++;
        if ((rn2 === 1'b0) && (setn2 === 1'b0)) begin
            bad++;
            $display("FAIL invariant dut_fast: rn=%b setn=%b required not both 0", rn2, setn2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b1;
        #1;
        total++; if (rn !== 1'b0)   begin bad++; $display("FAIL reset_rn: got %b want 0", rn); end
        total++; if (setn !== 1'b1) begin bad++; $display("FAIL reset_setn: got %b want 1", setn); end
        total++; if (ack !== 1'b0)  begin bad++; $display("FAIL reset_ack: got %b want 0", ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        tick();
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            total++;
            if (rn !== ((e == 6) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL release_rn edge%0d: got %b want %b", e, rn, (e == 6));
            end
            total++;
            if (setn !== 1'b1) begin bad++; $display("FAIL release_setn edge%0d: got %b want 1", e, setn); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy: got %b want 0", busy); end
    endtask

    task automatic do_release();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_set();
        set = 1'b1;
        tick();
        set = 1'b0;
        total++; if (setn !== 1'b0) begin bad++; $display("FAIL set_start_setn: got %b want 0", setn); end
        total++; if (rn !== 1'b1)   begin bad++; $display("FAIL set_start_rn: got %b want 1", rn); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL set_start_busy: got %b want 1", busy); end
        tick();
        total++; if (setn !== 1'b0) begin bad++; $display("FAIL set_mid_setn: got %b want 0", setn); end
        total++; if (ack !== 1'b0)  begin bad++; $display("FAIL set_mid_ack: got %b want 0", ack); end
        tick();
        total++; if (setn !== 1'b1) begin bad++; $display("FAIL set_end_setn: got %b want 1", setn); end
        total++; if (ack !== 1'b1)  begin bad++; $display("FAIL set_end_ack: got %b want 1", ack); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL set_gap_busy: got %b want 1", busy); end
        tick();
        total++; if (ack !== 1'b0)  begin bad++; $display("FAIL set_idle_ack: got %b want 0", ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL set_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_both();
        logic [6:0] exp_rn, exp_setn, exp_ack, exp_busy;
        exp_rn   = 7'b1111100;
        exp_setn = 7'b1100111;
        exp_ack  = 7'b0100100;
        exp_busy = 7'b0111111;
        clr = 1'b1;
        set = 1'b1;
        tick();
        clr = 1'b0;
        set = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            total++; if (rn !== exp_rn[i])     begin bad++; $display("FAIL both_rn s%0d: got %b want %b", i, rn, exp_rn[i]); end
            total++; if (setn !== exp_setn[i]) begin bad++; $display("FAIL both_setn s%0d: got %b want %b", i, setn, exp_setn[i]); end
            total++; if (ack !== exp_ack[i])   begin bad++; $display("FAIL both_ack s%0d: got %b want %b", i, ack, exp_ack[i]); end
            total++; if (busy !== exp_busy[i]) begin bad++; $display("FAIL both_busy s%0d: got %b want %b", i, busy, exp_busy[i]); end
        end
    endtask

    task automatic test_rst_mid();
        int glitches;
        set = 1'b1;
        tick();
        set = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++; if (setn !== 1'b1) begin bad++; $display("FAIL rstmid_setn: got %b want 1", setn); end
        total++; if (rn !== 1'b0)   begin bad++; $display("FAIL rstmid_rn: got %b want 0", rn); end
        total++; if (ack !== 1'b0)  begin bad++; $display("FAIL rstmid_ack: got %b want 0", ack); end
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        total++; if (rn !== 1'b1) begin bad++; $display("FAIL rstmid_release_rn: got %b want 1", rn); end
        glitches = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if ((rn !== 1'b1) || (setn !== 1'b1)) glitches++;
        end
        total++; if (glitches != 0) begin bad++; $display("FAIL rstmid_no_pulse: got %0d low cycles want 0", glitches); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    endtask

    task automatic test_merge();
        int lows;
        set = 1'b1;
        tick();
        set = 1'b0;
        clr = 1'b1;
        tick();
        tick();
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL merge_set_ack: got %b want 1", ack); end
        total++; if (rn !== 1'b1)  begin bad++; $display("FAIL merge_gap_rn: got %b want 1", rn); end
        tick();
        clr = 1'b0;
        total++; if (rn !== 1'b0) begin bad++; $display("FAIL merge_clr_start: got %b want 0", rn); end
        lows = (rn === 1'b0) ? 1 : 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (rn === 1'b0) lows++;
        end
        total++; if (lows != 2)     begin bad++; $display("FAIL merge_rn_low_cycles: got %0d want 2", lows); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL merge_busy: got %b want 0", busy); end
    endtask

    task automatic test_sweep();
        logic [7:0] exp_rn, exp_setn, exp_ack;
        int pulses, acks;
        exp_rn   = 8'b11111010;
        exp_setn = 8'b11101111;
        exp_ack  = 8'b00101010;
        rst2 = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            total++;
            if (rn2 !== ((e == 3) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL sweep_release_rn edge%0d: got %b want %b", e, rn2, (e == 3));
            end
        end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL sweep_idle_busy: got %b want 0", busy2); end
        pulses = 0;
        acks   = 0;
        for (int i = 0; i < 8; i++) begin
            clr2 = (i < 3);
            set2 = (i == 0);
            tick();
            if ((rn2 === 1'b0) || (setn2 === 1'b0)) pulses++;
            if (ack2 === 1'b1) acks++;
            total++; if (rn2 !== exp_rn[i])     begin bad++; $display("FAIL sweep_rn s%0d: got %b want %b", i, rn2, exp_rn[i]); end
            total++; if (setn2 !== exp_setn[i]) begin bad++; $display("FAIL sweep_setn s%0d: got %b want %b", i, setn2, exp_setn[i]); end
            total++; if (ack2 !== exp_ack[i])   begin bad++; $display("FAIL sweep_ack s%0d: got %b want %b", i, ack2, exp_ack[i]); end
        end
        clr2 = 1'b0;
        set2 = 1'b0;
        total++; if (pulses != 3)   begin bad++; $display("FAIL sweep_pulse_count: got %0d want 3", pulses); end
        total++; if (acks != pulses) begin bad++; $display("FAIL sweep_ack_count: got %0d want %0d", acks, pulses); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL sweep_end_busy: got %b want 0", busy2); end
    endtask

    initial begin
        rst  = 1'b0;
        clr  = 1'b0;
        set  = 1'b0;
        rst2 = 1'b1;
        clr2 = 1'b0;
        set2 = 1'b0;
        test_reset();
        tick();
        test_set();
        tick();
        test_both();
        tick();
        test_rst_mid();
        do_release();
        test_merge();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
